// File: rtl/bus_arb.sv
// Round-robin arbiter that grants one of NCH channels access to a single downstream bus.
// Optional BUSY watchdog is compiled in with BUS_ARB_TIMEOUT_EN.
module bus_arb #(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 16,
    parameter int unsigned DW  = 8,
    parameter int unsigned TMO = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NCH-1:0]    m_req_i,
    input  logic [NCH-1:0]    m_write_i,
    input  logic [NCH*AW-1:0] m_addr_i,
    input  logic [NCH*DW-1:0] m_wdata_i,
    output logic [DW-1:0]     m_rdata_o,
    output logic [NCH-1:0]    m_rdy_o,
    output logic              bus_req_o,
    output logic              bus_write_o,
    output logic [AW-1:0]     bus_addr_o,
    output logic [DW-1:0]     bus_wdata_o,
    input  logic [DW-1:0]     bus_rdata_i,
    input  logic              bus_rdy_i,
    output logic              err_o
);

    localparam int unsigned IW = $clog2(NCH);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic            bus_write_q, bus_write_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW-1:0]   m_rdata_q, m_rdata_d;
    logic [IW-1:0]   sel;

    // First requester found walking circularly from the channel after the last grant.
    always_comb begin
        int unsigned idx;
        logic [IW-1:0] cand;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx  = (32'(last_q) + 1 + k) % NCH;
            cand = IW'(idx);
            if (!found && m_req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        m_rdata_d   = m_rdata_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|m_req_i) begin
                    gnt_d       = sel;
                    bus_write_d = m_write_i[sel];
                    bus_addr_d  = m_addr_i[32'(sel)*AW +: AW];
                    bus_wdata_d = m_wdata_i[32'(sel)*DW +: DW];
                    state_d     = StBusy;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StBusy: begin
                if (bus_rdy_i) begin
                    m_rdata_d = bus_rdata_i;
                    last_d    = gnt_q;
                    state_d   = StDone;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TMO - 1)) begin
                    // Watchdog expiry completes the transaction with an error marker.
                    m_rdata_d = '1;
                    err_d     = 1'b1;
                    last_d    = gnt_q;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            last_q      <= IW'(NCH - 1);
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            m_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        m_rdy_o = '0;
        if (state_q == StDone) begin
            m_rdy_o[gnt_q] = 1'b1;
        end
    end

    assign bus_req_o   = (state_q == StBusy);
    assign bus_write_o = bus_write_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign m_rdata_o   = m_rdata_q;

endmodule

// File: tb/tb_bus_arb.sv
// Directed self-checking bench for bus_arb with three channels and TMO=8.
module tb_bus_arb;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 8;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    m_req;
    logic [NCH-1:0]    m_write;
    logic [NCH*AW-1:0] m_addr;
    logic [NCH*DW-1:0] m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [NCH-1:0]    m_rdy;
    logic              bus_req;
    logic              bus_write;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW-1:0]     bus_rdata;
    logic              bus_rdy;
    logic              err;

    int total = 0;
    int bad   = 0;

    bus_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m_req_i     (m_req),
        .m_write_i   (m_write),
        .m_addr_i    (m_addr),
        .m_wdata_i   (m_wdata),
        .m_rdata_o   (m_rdata),
        .m_rdy_o     (m_rdy),
        .bus_req_o   (bus_req),
        .bus_write_o (bus_write),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_rdata_i (bus_rdata),
        .bus_rdy_i   (bus_rdy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        m_req     = '0;
        m_write   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        bus_rdata = '0;
        bus_rdy   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
        total++; if (m_rdy !== 3'b000) begin bad++; $display("FAIL rst_m_rdy got=%b exp=000", m_rdy); end
        total++; if (bus_addr !== 16'h0000) begin bad++; $display("FAIL rst_bus_addr got=%h exp=0000", bus_addr); end
        total++; if (bus_write !== 1'b0 || bus_wdata !== 8'h00) begin bad++; $display("FAIL rst_bus_cmd got=%b/%h exp=0/00", bus_write, bus_wdata); end
        total++; if (m_rdata !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL rst_rdata_err got=%h/%b exp=00/0", m_rdata, err); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        m_addr[0*AW +: AW] = 16'h0123;
        m_req = 3'b001;
        step();
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rd_bus_req got=%b exp=1", bus_req); end
        total++; if (bus_addr !== 16'h0123 || bus_write !== 1'b0) begin bad++; $display("FAIL rd_cmd got=%h/%b exp=0123/0", bus_addr, bus_write); end
        for (int i = 0; i < 4; i++) step();
        total++; if (bus_req !== 1'b1 || m_rdy !== 3'b000) begin bad++; $display("FAIL rd_wait got=%b/%b exp=1/000", bus_req, m_rdy); end
        bus_rdata = 8'hA5;
        bus_rdy   = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = '0;
        total++; if (m_rdy !== 3'b001) begin bad++; $display("FAIL rd_m_rdy got=%b exp=001", m_rdy); end
        total++; if (m_rdata !== 8'hA5 || bus_req !== 1'b0) begin bad++; $display("FAIL rd_rdata got=%h/%b exp=a5/0", m_rdata, bus_req); end
        step();
        total++; if (m_rdy !== 3'b000) begin bad++; $display("FAIL rd_done_one_cycle got=%b exp=000", m_rdy); end
    endtask

    task automatic test_rdy_outside();
        // m_rdata still a5 from the previous read
        bus_rdata = 8'h77;
        bus_rdy   = 1'b1;
        step();
        bus_rdy = 1'b0;
        step();
        total++; if (m_rdata !== 8'hA5 || m_rdy !== 3'b000 || bus_req !== 1'b0) begin bad++; $display("FAIL rdy_idle got=%h/%b/%b exp=a5/000/0", m_rdata, m_rdy, bus_req); end
    endtask

    task automatic test_round_robin();
        int waited;
        do_reset();
        for (int i = 0; i < NCH; i++) m_addr[i*AW +: AW] = 16'h1000 + 16'(i);
        m_write = 3'b111;
        m_req   = 3'b111;
        for (int t = 0; t < 6; t++) begin
            waited = 0;
            while (bus_req !== 1'b1 && waited < 10) begin step(); waited++; end
            total++; if (bus_addr !== 16'h1000 + 16'(t % 3)) begin bad++; $display("FAIL rr_grant%0d got=%h exp=%h", t, bus_addr, 16'h1000 + 16'(t % 3)); end
            bus_rdy = 1'b1;
            step();
            bus_rdy = 1'b0;
            total++; if (m_rdy !== 3'(1 << (t % 3))) begin bad++; $display("FAIL rr_rdy%0d got=%b exp=%b", t, m_rdy, 3'(1 << (t % 3))); end
        end
        m_req   = '0;
        m_write = '0;
        step();
    endtask

    task automatic test_hold();
        do_reset();
        m_req   = 3'b010;
        m_write = 3'b010;
        m_addr[1*AW +: AW]  = 16'h7FFF;
        m_wdata[1*DW +: DW] = 8'h3C;
        step();
        m_addr[1*AW +: AW]  = 16'h0000;
        m_wdata[1*DW +: DW] = 8'h00;
        m_write = 3'b000;
        m_req   = 3'b011;
        step();
        total++; if (bus_req !== 1'b1 || bus_addr !== 16'h7FFF) begin bad++; $display("FAIL hold_addr got=%b/%h exp=1/7fff", bus_req, bus_addr); end
        total++; if (bus_write !== 1'b1 || bus_wdata !== 8'h3C) begin bad++; $display("FAIL hold_wr got=%b/%h exp=1/3c", bus_write, bus_wdata); end
        bus_rdata = 8'h5A;
        bus_rdy   = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = '0;
        total++; if (m_rdy !== 3'b010 || m_rdata !== 8'h5A) begin bad++; $display("FAIL hold_done got=%b/%h exp=010/5a", m_rdy, m_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_addr[0*AW +: AW] = 16'h2000;
        m_addr[1*AW +: AW] = 16'h2001;
        m_req = 3'b001;
        step();
        bus_rdy = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = 3'b011;
        step();
        step();
        total++; if (bus_addr !== 16'h2001) begin bad++; $display("FAIL mid_grant1 got=%h exp=2001", bus_addr); end
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0 || m_rdy !== 3'b000) begin bad++; $display("FAIL mid_rst got=%b/%b exp=0/000", bus_req, m_rdy); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (bus_req !== 1'b1 || bus_addr !== 16'h2000 || m_rdy !== 3'b000) begin bad++; $display("FAIL mid_regrant got=%b/%h/%b exp=1/2000/000", bus_req, bus_addr, m_rdy); end
        bus_rdy = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = '0;
        total++; if (m_rdy !== 3'b001) begin bad++; $display("FAIL mid_rdy got=%b exp=001", m_rdy); end
        step();
    endtask

    task automatic test_drop();
        do_reset();
        m_req = 3'b001;
        step();
        m_req = 3'b011;
        step();
        m_req = 3'b001;
        bus_rdy = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = '0;
        step();
        step();
        step();
        total++; if (bus_req !== 1'b0 || m_rdy !== 3'b000 || err !== 1'b0) begin bad++; $display("FAIL drop got=%b/%b/%b exp=0/000/0", bus_req, m_rdy, err); end
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        // Ready on the final watchdog cycle takes priority.
        do_reset();
        m_req = 3'b100;
        step();
        for (int i = 0; i < 7; i++) step();
        total++; if (bus_req !== 1'b1 || m_rdy !== 3'b000) begin bad++; $display("FAIL tmo_wait got=%b/%b exp=1/000", bus_req, m_rdy); end
        bus_rdata = 8'h42;
        bus_rdy   = 1'b1;
        step();
        bus_rdy = 1'b0;
        total++; if (m_rdy !== 3'b100 || m_rdata !== 8'h42 || err !== 1'b0) begin bad++; $display("FAIL tmo_race got=%b/%h/%b exp=100/42/0", m_rdy, m_rdata, err); end
        step();
        // No ready at all: watchdog fires after 8 busy cycles.
        step();
        for (int i = 0; i < 7; i++) step();
        total++; if (bus_req !== 1'b1 || m_rdy !== 3'b000) begin bad++; $display("FAIL tmo_wait2 got=%b/%b exp=1/000", bus_req, m_rdy); end
        step();
        m_req = 3'b001;
        total++; if (m_rdy !== 3'b100 || m_rdata !== 8'hFF || err !== 1'b1) begin bad++; $display("FAIL tmo_fire got=%b/%h/%b exp=100/ff/1", m_rdy, m_rdata, err); end
        step();
        step();
        bus_rdata = 8'h11;
        bus_rdy   = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = '0;
        total++; if (m_rdy !== 3'b001 || m_rdata !== 8'h11 || err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b/%h/%b exp=001/11/1", m_rdy, m_rdata, err); end
        step();
    endtask
`else
    task automatic test_timeout();
        int busy_cycles;
        do_reset();
        m_req = 3'b100;
        step();
        busy_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus_req === 1'b1 && m_rdy === 3'b000 && err === 1'b0) busy_cycles++;
            step();
        end
        total++; if (busy_cycles !== 1000) begin bad++; $display("FAIL notmo_busy got=%0d exp=1000", busy_cycles); end
        bus_rdata = 8'h99;
        bus_rdy   = 1'b1;
        step();
        bus_rdy = 1'b0;
        m_req   = '0;
        total++; if (m_rdy !== 3'b100 || m_rdata !== 8'h99 || err !== 1'b0) begin bad++; $display("FAIL notmo_done got=%b/%h/%b exp=100/99/0", m_rdy, m_rdata, err); end
        step();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        m_req     = '0;
        m_write   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        bus_rdata = '0;
        bus_rdy   = 1'b0;
        test_reset();
        test_single_read();
        test_rdy_outside();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_drop();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
